// File: rtl/mdu_hilo_if.sv
// Request/response bundle between the ALU issue logic and the HI/LO multiply-divide unit.
// The ALU drives requests as master; mdu_hilo is the slave and owns hi/lo.
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, op_code, src_a, src_b, cancel,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  op_valid, op_code, src_a, src_b, cancel,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative shift-add multiplier / restoring divider owning the architectural HI/LO pair.
// Operands are reduced to magnitudes on accept; the sign fix-up happens in a single FIX step.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       resetn,
    mdu_hilo_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;      // mult: {acc, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic               neg_res, neg_rem, is_div, dz;

    logic               accept, is_muldiv, sgn;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_top;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // A flush in IDLE also swallows a request presented on the same edge.
    assign accept    = bus.op_valid & (state == IDLE) & ~bus.cancel;
    assign is_muldiv = ~bus.op_code[2];
    assign sgn       = ~bus.op_code[0];
    assign abs_a     = (sgn & bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    assign abs_b     = (sgn & bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    assign div_top   = prod[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_top >= {1'b0, opnd};
    // Remainder stays below the divisor, so the trial difference fits in WIDTH bits.
    assign div_sub   = div_top[WIDTH-1:0] - opnd;

    assign prod_fix  = neg_res ? -prod : prod;
    assign quo_fix   = neg_res ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    assign rem_fix   = neg_rem ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // NOTE: a default assignment first keeps this combinational block from inferring a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept && is_muldiv)
                      state_nxt = !bus.op_code[1] ? MUL : ((bus.src_b == '0) ? FIX : DIV);
            MUL, DIV: if (bus.cancel)                     state_nxt = IDLE;
                      else if (cnt == CW'(WIDTH - 1))     state_nxt = FIX;
            FIX:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
    end

    // NOTE: every register here is small control/datapath state, so all of it takes the async reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt          <= '0;
            prod         <= '0;
            opnd         <= '0;
            neg_res      <= 1'b0;
            neg_rem      <= 1'b0;
            is_div       <= 1'b0;
            dz           <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.hi       <= '0;
            bus.lo       <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    if (bus.op_code == 3'b100)      bus.hi <= bus.src_a;
                    else if (bus.op_code == 3'b101) bus.lo <= bus.src_a;
                    else if (is_muldiv) begin
                        cnt     <= '0;
                        prod    <= {{WIDTH{1'b0}}, bus.op_code[1] ? abs_a : abs_b};
                        opnd    <= bus.op_code[1] ? abs_b : abs_a;
                        neg_res <= sgn & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                        neg_rem <= sgn & bus.op_code[1] & bus.src_a[WIDTH-1];
                        is_div  <= bus.op_code[1];
                        dz      <= bus.op_code[1] & (bus.src_b == '0);
                    end
                end
                MUL: if (!bus.cancel) begin
                    prod <= {mul_sum, prod[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                end
                DIV: if (!bus.cancel) begin
                    prod <= div_ge ? {div_sub, prod[WIDTH-2:0], 1'b1}
                                   : {div_top[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
                    cnt  <= cnt + 1'b1;
                end
                FIX: if (!bus.cancel) begin
                    bus.done     <= 1'b1;
                    bus.div_zero <= dz;
                    if (!dz) begin
                        if (is_div) begin
                            bus.hi <= rem_fix;
                            bus.lo <= quo_fix;
                        end else begin
                            bus.hi <= prod_fix[2*WIDTH-1:WIDTH];
                            bus.lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed and randomized checks of mdu_hilo against an arithmetic HI/LO reference model.
module tb_mdu_hilo;
    logic clk = 1'b0;
    logic resetn;
    int   vectors = 0;
    int   miscompares = 0;

    logic [31:0] mhi = '0, mlo = '0;
    logic [31:0] pend_h, pend_l;
    bit          pend_dz;

    mdu_hilo_if #(.WIDTH(32)) bus ();
    mdu_hilo #(.WIDTH(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one request computed with plain 64-bit arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] h, inout logic [31:0] l, output bit dz);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        case (op)
            3'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
            3'd2: if (b == 0) dz = 1'b1;
                  else begin
                      q = sa / sb; r = sa % sb;
                      p = 64'(q); l = p[31:0];
                      p = 64'(r); h = p[31:0];
                  end
            3'd3: if (b == 0) dz = 1'b1;
                  else begin l = a / b; h = a % b; end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        bus.src_a    = a;
        bus.src_b    = b;
        tick();
        bus.op_valid = 1'b0;
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        pend_h = mhi;
        pend_l = mlo;
        model(op, a, b, pend_h, pend_l, pend_dz);
        drive(op, a, b);
    endtask

    task automatic finish_op(input int n0);
        int n = n0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        check("latency", 32'(n), pend_dz ? 32'd1 : 32'd33);
        check("done", 32'(bus.done), 32'd1);
        check("div_zero", 32'(bus.div_zero), 32'(pend_dz));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("hi", bus.hi, pend_h);
        check("lo", bus.lo, pend_l);
        mhi = pend_h;
        mlo = pend_l;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start_op(op, a, b);
        if (!op[2]) begin
            check("busy_after_accept", 32'(bus.busy), 32'd1);
            finish_op(0);
        end else begin
            check("busy_move", 32'(bus.busy), 32'd0);
            check("hi_move", bus.hi, pend_h);
            check("lo_move", bus.lo, pend_l);
            mhi = pend_h;
            mlo = pend_l;
        end
    endtask

    initial begin
        bit          seen_done;
        logic [2:0]  op;
        logic [31:0] a, b;

        resetn       = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_code  = '0;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.cancel   = 1'b0;
        repeat (2) tick();
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dz", 32'(bus.div_zero), 32'd0);
        @(negedge clk) resetn = 1'b1;
        tick();

        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
        check("mult_hi_k", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo_k", bus.lo, 32'hFFFF_FFFE);
        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        check("multu_hi_k", bus.hi, 32'h0000_0001);
        check("multu_lo_k", bus.lo, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_k", bus.lo, 32'hFFFF_FFFD);
        check("div_hi_k", bus.hi, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd100, 32'd7);
        check("divu_lo_k", bus.lo, 32'd14);
        check("divu_hi_k", bus.hi, 32'd2);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_lo_k", bus.lo, 32'h8000_0000);
        check("ovf_hi_k", bus.hi, 32'd0);

        run_op(3'd4, 32'h0000_1234, 32'd0);
        run_op(3'd3, 32'd5, 32'd0);
        check("dz_hi_k", bus.hi, 32'h0000_1234);
        tick();
        check("dz_done_clear", 32'(bus.done), 32'd0);

        // A move issued while a multiply runs must be ignored.
        start_op(3'd0, 32'h0000_0123, 32'hFFFF_FF00);
        repeat (3) tick();
        drive(3'd5, 32'h0000_AAAA, 32'd0);
        finish_op(4);
        run_op(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

        // Flush at iteration 10 of a divide.
        start_op(3'd2, 32'hFFFF_0000, 32'd3);
        repeat (9) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("cancel_busy", 32'(bus.busy), 32'd0);
        seen_done = 1'b0;
        repeat (40) begin
            if (bus.done) seen_done = 1'b1;
            tick();
        end
        check("cancel_no_done", 32'(seen_done), 32'd0);
        check("cancel_hi", bus.hi, mhi);
        check("cancel_lo", bus.lo, mlo);

        bus.cancel = 1'b1;
        drive(3'd4, 32'hDEAD_BEEF, 32'd0);
        bus.cancel = 1'b0;
        check("idle_cancel_hi", bus.hi, mhi);
        check("idle_cancel_busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (i % 7 == 3) a = 32'h8000_0000;
            run_op(op, a, b);
        end

        // Asynchronous reset part-way through a multiply.
        start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) tick();
        #2 resetn = 1'b0;
        #1;
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk) resetn = 1'b1;
        tick();
        mhi = '0;
        mlo = '0;
        run_op(3'd3, 32'd1000, 32'd33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
